// File: rtl/divider_param.sv
// Multi-cycle radix-2 restoring divider with signed/unsigned select, divide-by-zero
// flag and optional early-out; result is packed as {remainder, quotient}.
module divider_param #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          EARLY_OUT = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               annul_i,
    input  logic               signed_i,
    input  logic [WIDTH-1:0]   opdata1_i,
    input  logic [WIDTH-1:0]   opdata2_i,
    output logic [2*WIDTH-1:0] result_o,
    output logic               ready_o,
    output logic               div_zero_o,
    output logic               busy_o
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [2:0] {S_IDLE, S_ZERO, S_ON, S_FIX, S_END} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;       // {partial remainder, dividend bits / quotient bits}
    logic [WIDTH-1:0]   dvs_mag;
    logic [CW-1:0]      cnt;
    logic               sgn;
    logic               msb1;
    logic               msb2;
    logic               dz;

    logic [WIDTH-1:0]   mag1_c;
    logic [WIDTH-1:0]   mag2_c;
    logic [WIDTH:0]     trial_c;
    logic [WIDTH-1:0]   quo_fix_c;
    logic [WIDTH-1:0]   rem_fix_c;

    // Operand magnitudes, trial subtraction and final sign correction.
    always_comb begin
        mag1_c    = (signed_i && opdata1_i[WIDTH-1]) ? (~opdata1_i + WIDTH'(1)) : opdata1_i;
        mag2_c    = (signed_i && opdata2_i[WIDTH-1]) ? (~opdata2_i + WIDTH'(1)) : opdata2_i;
        trial_c   = acc[2*WIDTH-1:WIDTH-1] - {1'b0, dvs_mag};
        quo_fix_c = (sgn && (msb1 != msb2)) ? (~acc[WIDTH-1:0] + WIDTH'(1)) : acc[WIDTH-1:0];
        rem_fix_c = (sgn && msb1) ? (~acc[2*WIDTH-1:WIDTH] + WIDTH'(1)) : acc[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            acc        <= '0;
            dvs_mag    <= '0;
            cnt        <= '0;
            sgn        <= 1'b0;
            msb1       <= 1'b0;
            msb2       <= 1'b0;
            dz         <= 1'b0;
            result_o   <= '0;
            ready_o    <= 1'b0;
            div_zero_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    result_o   <= '0;
                    ready_o    <= 1'b0;
                    div_zero_o <= 1'b0;
                    if (start_i && !annul_i) begin
                        sgn     <= signed_i;
                        msb1    <= opdata1_i[WIDTH-1];
                        msb2    <= opdata2_i[WIDTH-1];
                        dvs_mag <= mag2_c;
                        cnt     <= '0;
                        dz      <= 1'b0;
                        busy_o  <= 1'b1;
                        if (opdata2_i == '0) begin
                            state <= S_ZERO;
                        end else if (EARLY_OUT && (mag1_c < mag2_c)) begin
                            acc   <= {mag1_c, WIDTH'(0)};
                            state <= S_FIX;
                        end else begin
                            acc   <= {WIDTH'(0), mag1_c};
                            state <= S_ON;
                        end
                    end
                end
                S_ZERO: begin
                    if (annul_i) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc   <= '0;
                        dz    <= 1'b1;
                        state <= S_END;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        // Keep the trial difference only when it did not borrow.
                        if (!trial_c[WIDTH]) begin
                            acc <= {trial_c[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
                        end else begin
                            acc <= {acc[2*WIDTH-2:0], 1'b0};
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (annul_i) begin
                        state  <= S_IDLE;
                        busy_o <= 1'b0;
                    end else begin
                        acc   <= {rem_fix_c, quo_fix_c};
                        state <= S_END;
                    end
                end
                S_END: begin
                    // First END cycle publishes the result; afterwards wait for start_i to drop.
                    if (!ready_o) begin
                        result_o   <= acc;
                        ready_o    <= 1'b1;
                        div_zero_o <= dz;
                    end else if (!start_i) begin
                        state      <= S_IDLE;
                        result_o   <= '0;
                        ready_o    <= 1'b0;
                        div_zero_o <= 1'b0;
                        busy_o     <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_divider_param.sv
// Bench for divider_param: two instances (early-out on / off) checked every cycle
// against a transaction-level arithmetic model, plus hand-computed literal cases.
module tb_divider_param;
    localparam int unsigned W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           start [2];
    logic           annul [2];
    logic           sgn   [2];
    logic [W-1:0]   op1   [2];
    logic [W-1:0]   op2   [2];
    logic [2*W-1:0] result[2];
    logic           ready [2];
    logic           dz    [2];
    logic           busy  [2];

    divider_param #(.WIDTH(W), .EARLY_OUT(1'b1)) u_eo (
        .clk(clk), .rst(rst), .start_i(start[0]), .annul_i(annul[0]), .signed_i(sgn[0]),
        .opdata1_i(op1[0]), .opdata2_i(op2[0]), .result_o(result[0]), .ready_o(ready[0]),
        .div_zero_o(dz[0]), .busy_o(busy[0])
    );

    divider_param #(.WIDTH(W), .EARLY_OUT(1'b0)) u_full (
        .clk(clk), .rst(rst), .start_i(start[1]), .annul_i(annul[1]), .signed_i(sgn[1]),
        .opdata1_i(op1[1]), .opdata2_i(op2[1]), .result_o(result[1]), .ready_o(ready[1]),
        .div_zero_o(dz[1]), .busy_o(busy[1])
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference result from plain integer division (truncating, remainder takes dividend sign).
    function automatic void expect_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic eo, output logic [2*W-1:0] res,
                                      output logic z, output int lat);
        longint sa, sb, q, r, ma, mb;
        if (b == '0) begin
            res = '0;
            z   = 1'b1;
            lat = 2;
            return;
        end
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q   = sa / sb;
        r   = sa % sb;
        res = {r[W-1:0], q[W-1:0]};
        z   = 1'b0;
        ma  = (sa < 0) ? -sa : sa;
        mb  = (sb < 0) ? -sb : sb;
        lat = (eo && (ma < mb)) ? 2 : int'(W) + 2;
    endfunction

    // Transaction-level model: expected outputs per DUT, advanced each rising edge.
    logic           m_busy [2];
    logic           m_ready[2];
    logic           m_dz   [2];
    logic [2*W-1:0] m_res  [2];
    logic [2*W-1:0] p_res  [2];
    logic           p_dz   [2];
    int             m_left [2];

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_dz[k] = 1'b0; m_res[k] = '0; m_left[k] = 0;
            end else if (!m_busy[k]) begin
                if (start[k] && !annul[k]) begin
                    expect_op(sgn[k], op1[k], op2[k], (k == 0), p_res[k], p_dz[k], m_left[k]);
                    m_busy[k] = 1'b1;
                end
            end else if (m_left[k] > 0) begin
                // Annul counts only before the final (result-publishing) cycle.
                if (annul[k] && m_left[k] >= 2) begin
                    m_busy[k] = 1'b0;
                    m_left[k] = 0;
                end else begin
                    m_left[k] = m_left[k] - 1;
                    if (m_left[k] == 0) begin
                        m_ready[k] = 1'b1;
                        m_res[k]   = p_res[k];
                        m_dz[k]    = p_dz[k];
                    end
                end
            end else if (!start[k]) begin
                m_busy[k] = 1'b0; m_ready[k] = 1'b0; m_dz[k] = 1'b0; m_res[k] = '0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("cyc dut%0d ready", k), 64'(ready[k]), 64'(m_ready[k]));
                check($sformatf("cyc dut%0d result", k), result[k], m_res[k]);
                check($sformatf("cyc dut%0d div_zero", k), 64'(dz[k]), 64'(m_dz[k]));
                check($sformatf("cyc dut%0d busy", k), 64'(busy[k]), 64'(m_busy[k]));
            end
        end
    end

    task automatic do_op(input int k, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [2*W-1:0] res, output logic z, output int lat);
        int n;
        bit got;
        @(negedge clk);
        start[k] = 1'b1; sgn[k] = s; op1[k] = a; op2[k] = b;
        n = 0;
        got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            op1[k] = $urandom; op2[k] = $urandom; sgn[k] = 1'($urandom_range(0, 1));
            if (ready[k]) got = 1'b1;
        end
        if (!got) begin
            n_tests++;
            n_fail++;
            $display("FAIL dut%0d wait_ready: got no ready within %0d cycles, expected ready", k, n);
        end
        res = result[k];
        z   = dz[k];
        lat = n - 1;
        repeat ($urandom_range(0, 3)) begin
            annul[k] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        annul[k] = 1'b0;
        start[k] = 1'b0;
        @(negedge clk);
    endtask

    task automatic lit(input string name, input int k, input logic s, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2*W-1:0] e_res, input logic e_z,
                       input int e_lat);
        logic [2*W-1:0] res;
        logic           z;
        int             lat;
        do_op(k, s, a, b, res, z, lat);
        check({name, " result"}, res, e_res);
        check({name, " div_zero"}, 64'(z), 64'(e_z));
        check({name, " latency"}, 64'(lat), 64'(e_lat));
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return W'(1);
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return W'($urandom_range(0, 15));
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [2*W-1:0] res, e_res;
        logic           z, e_z;
        int             lat, e_lat, k;
        logic           s;
        logic [W-1:0]   a, b;

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0; annul[i] = 1'b0; sgn[i] = 1'b0; op1[i] = '0; op2[i] = '0;
        end
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("reset result", result[0], 64'd0);
        check("reset ready", 64'(ready[1]), 64'd0);
        check("reset busy", 64'(busy[0]), 64'd0);
        rst = 1'b0;

        lit("udiv 100/7", 0, 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 34);
        lit("sdiv -7/2", 0, 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 34);
        lit("sdiv 7/-2", 1, 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 34);
        lit("sdiv by zero", 0, 1'b1, 32'h1234, 32'd0, 64'd0, 1'b1, 2);
        lit("udiv by zero", 1, 1'b0, 32'h1234, 32'd0, 64'd0, 1'b1, 2);
        lit("early 5/9", 0, 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 1'b0, 2);
        lit("full 5/9", 1, 1'b0, 32'd5, 32'd9, {32'd5, 32'd0}, 1'b0, 34);
        lit("early -5/9", 0, 1'b1, 32'hFFFF_FFFB, 32'd9, {32'hFFFF_FFFB, 32'd0}, 1'b0, 2);
        lit("minneg/-1", 0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 34);
        lit("umax/1", 1, 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, 34);

        // Annul partway through the iterations.
        @(negedge clk);
        start[1] = 1'b1; sgn[1] = 1'b0; op1[1] = 32'd100; op2[1] = 32'd7;
        repeat (11) @(negedge clk);
        annul[1] = 1'b1; start[1] = 1'b0;
        @(negedge clk);
        annul[1] = 1'b0;
        check("annul busy", 64'(busy[1]), 64'd0);
        repeat (40) @(negedge clk);
        check("annul ready", 64'(ready[1]), 64'd0);

        // Reset in the middle of an operation.
        start[0] = 1'b1; sgn[0] = 1'b0; op1[0] = 32'd1000; op2[0] = 32'd3;
        repeat (6) @(negedge clk);
        rst = 1'b1; start[0] = 1'b0;
        @(negedge clk);
        check("midrst result", result[0], 64'd0);
        check("midrst ready", 64'(ready[0]), 64'd0);
        check("midrst busy", 64'(busy[0]), 64'd0);
        rst = 1'b0;

        for (int i = 0; i < 150; i++) begin
            k = int'($urandom_range(0, 1));
            s = 1'($urandom_range(0, 1));
            a = pick();
            b = pick();
            do_op(k, s, a, b, res, z, lat);
            expect_op(s, a, b, (k == 0), e_res, e_z, e_lat);
            check($sformatf("rand%0d result", i), res, e_res);
            check($sformatf("rand%0d div_zero", i), 64'(z), 64'(e_z));
            check($sformatf("rand%0d latency", i), 64'(lat), 64'(e_lat));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1);
    end
endmodule
